// File: rtl/sc_defs.sv
// Shared definitions for the single-cycle core front end: next-PC select
// codes (also used by the control unit), fetch FSM states and fault causes.
package sc_defs;

  // Next-PC select codes driven by the control unit.
  localparam logic [1:0] PCSRC_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PCSRC_BR  = 2'b01;  // branch target
  localparam logic [1:0] PCSRC_JR  = 2'b10;  // register target (jr)
  localparam logic [1:0] PCSRC_J   = 2'b11;  // jump target (j/jal)

  // Sticky fault cause codes.
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_REQ   = 2'b00,
    ST_EXEC  = 2'b01,
    ST_FAULT = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/sc_npc_mux.sv
// Next-PC selection: pure 4:1 mux on the control unit's pcsource code, plus
// a flag telling the fetch FSM the chosen target is not word aligned.
module sc_npc_mux
  import sc_defs::*;
(
  input  logic [1:0]  pcsource,
  input  logic [31:0] pc4,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  output logic [31:0] npc,
  output logic        misaligned
);

  // Select the next PC and flag a non-word-aligned result.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    npc = pc4;
    case (pcsource)
      PCSRC_BR: npc = bpc;
      PCSRC_JR: npc = da;
      PCSRC_J:  npc = jpc;
      default:  npc = pc4;
    endcase
    misaligned = |npc[1:0];
  end

endmodule

// File: rtl/sc_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches each instruction over a
// req/ack handshake, presents it to decode and commits the next PC on retire.
module sc_fetch_unit
  import sc_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [1:0]       pcsource,
  input  logic [31:0]      bpc,
  input  logic [31:0]      da,
  input  logic [31:0]      jpc,
  input  logic             retire,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic             inst_valid,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       npc;
  logic              npc_misaligned;

  assign pc4 = pc_q + 32'd4;

  sc_npc_mux u_npc_mux (
    .pcsource   (pcsource),
    .pc4        (pc4),
    .bpc        (bpc),
    .da         (da),
    .jpc        (jpc),
    .npc        (npc),
    .misaligned (npc_misaligned)
  );

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    req_d   = req_q;
    valid_d = valid_q;
    fault_d = fault_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      ST_REQ: begin
        if (!req_q) begin
          // First cycle after reset: raise the request; a stray ack is ignored.
          req_d = 1'b1;
        end else if (imem_ack) begin
          inst_d  = imem_rdata;
          wait_d  = '0;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ST_EXEC;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          req_d   = 1'b0;
          fault_d = 1'b1;
          cause_d = FAULT_TIMEOUT;
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_EXEC: begin
        if (retire) begin
          cnt_d   = cnt_q + 1'b1;
          valid_d = 1'b0;
          if (npc_misaligned) begin
            // PC stays on the retiring instruction so software can see where it went wrong.
            fault_d = 1'b1;
            cause_d = FAULT_MISALIGN;
            state_d = ST_FAULT;
          end else begin
            pc_d    = npc;
            req_d   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      default: begin
        // ST_FAULT is terminal; request and valid are already low.
        state_d = ST_FAULT;
      end
    endcase
  end

  // State and registered outputs; reset drops the request asynchronously.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: every register here is a plain flop with a defined reset value; there is no storage array to leave unreset.
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= FAULT_NONE;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make all flops update together from pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign inst        = inst_q;
  assign pc          = pc_q;
  assign inst_valid  = valid_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign retired_cnt = cnt_q;

endmodule
